sa_w_arb_q: RTL and testbench
=============================

Name: sa_w_arb_q

Overview:
- Parametrised, registered write arbiter for the status array, generalised from a 2-way combinational mux to NUM_SRC requesters.
- Each requester owns a one-entry holding slot with a valid/ready handshake.
- Valid slots are arbitrated by strict priority or round-robin into a registered write port with backpressure.
- Sits between the use-bit updater / miss handler and other SA writers and the status array write port.

Parameters:
- SET_ADDR_WIDTH, 4, set index width
- NUM_WAYS, 4, ways per set (one mask bit per way)
- SA_WORD_WIDTH, 8, status word width; must be a multiple of NUM_WAYS (WAY_BITS = SA_WORD_WIDTH/NUM_WAYS)
- NUM_SRC, 2, number of write sources (>=2); source 0 is the miss handler

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_src_set_addr  input  NUM_SRC*SET_ADDR_WIDTH  per-source set address, source k at bits [k*SET_ADDR_WIDTH +: SET_ADDR_WIDTH]
- i_src_data  input  NUM_SRC*SA_WORD_WIDTH  per-source status word
- i_src_mask  input  NUM_SRC*NUM_WAYS  per-source way write mask
- i_src_valid  input  NUM_SRC  per-source request
- o_src_ready  output  NUM_SRC  slot k empty, request accepted on valid&ready
- i_prio_mode  input  1  1: strict priority (lowest index wins); 0: round-robin
- o_w_set_addr  output  SET_ADDR_WIDTH  SA write set
- o_w_data  output  SA_WORD_WIDTH  SA write data
- o_w_mask  output  NUM_WAYS  SA write mask
- o_w_valid  output  1  SA write valid
- i_w_ready  input  1  SA accepts write when high with o_w_valid
- o_busy  output  1  any slot or output register occupied

Behaviour:
- Reset (async, i_rst_n low): all slots empty, output register empty, o_w_valid=0, o_w_set_addr/o_w_data/o_w_mask=0, rr pointer=0, o_busy=0. Inputs ignored while reset is low. Reset mid-operation discards all pending writes.
- o_src_ready[k] = ~slot_valid[k]: registered state only, no combinational path from any input.
- Capture: on valid&ready, slot k loads addr/data/mask at the edge.
- Data sanitise: data bits of ways with mask=0 are stored as 0. A request with mask==0 is accepted but never stored or issued.
- Output load condition: output register empty, or o_w_valid&i_w_ready at this edge.
- On load: winner slot contents move to the output register and the winner slot clears at the same edge. No valid slot: o_w_valid goes 0 (if the old entry was accepted).
- Hold: while o_w_valid&~i_w_ready, output fields are stable and no slot is granted.
- Latency: input accept at edge N, o_w_valid high after edge N+1 (minimum, output free).
- Throughput: one write/cycle aggregate. Each source is limited to one accept per 2 cycles.
- Strict mode: lowest-index valid slot wins; rr pointer unchanged.
- Round-robin mode: search starts at the rr pointer and wraps modulo NUM_SRC. After each grant, pointer = winner+1, wrapping NUM_SRC-1 to 0.
- Mode change takes effect at the next grant decision; the pointer is retained.
- Same-set ordering: writes from one source issue in acceptance order. No ordering is guaranteed across sources except through priority.
- o_busy = |slot_valid | o_w_valid.

Optional Feature:
- Macro: SA_W_ARB_MERGE_EN.
- Defined: at grant, every other valid slot with set address equal to the winner's merges into the same output write.
  - o_w_mask = OR of the masks.
  - Per way, data comes from the highest-priority contributing source (lowest index in strict mode; nearest to the rr pointer in RR mode).
  - All merged slots clear at the same edge. The rr pointer advances past the winner only.
- Undefined: one slot per output write. No address comparators are instantiated.

Test Plan:
- Reset: assert i_rst_n=0 mid-traffic with slots full → immediately o_w_valid=0, outputs 0, o_src_ready=2'b11 after release, no stale write ever issued.
- Single write: src1 addr=4'h3 data=8'hFF mask=4'b0101, i_w_ready=1 → o_w_valid after next edge, addr 3, data 8'h33, mask 4'b0101, for exactly 1 cycle.
- Strict priority: i_prio_mode=1, both sources valid continuously with distinct addresses → src0 wins every contended grant, src1 issues only when slot0 is empty.
- Round-robin: i_prio_mode=0, both sources valid continuously → grants alternate 0,1,0,1. Swap to strict mid-stream → next grant goes to the lowest index.
- Backpressure: i_w_ready=0 for 5 cycles with o_w_valid=1 → output fields stable, both slots hold, o_src_ready=0. Release → the held write is issued, then the slots drain in arbitration order.
- Zero-mask/merge: src0 mask=0 → accepted, no o_w_valid. With SA_W_ARB_MERGE_EN, src0 {set 2, mask 0011, data 8'h05} and src1 {set 2, mask 0110, data 8'h28} both pending, strict mode → a single write with mask 0111, data 8'h25.

Source files
------------

// File: rtl/sa_w_arb_q.sv
// sa_w_arb_q: registered write arbiter for the status array.
// Each source owns a one-entry slot; valid slots are arbitrated (strict priority or
// round-robin) into a single registered write port with backpressure.
// Optional feature: define SA_W_ARB_MERGE_EN to merge same-set pending slots into one write.
module sa_w_arb_q #(
    parameter int unsigned SET_ADDR_WIDTH = 4,
    parameter int unsigned NUM_WAYS       = 4,
    parameter int unsigned SA_WORD_WIDTH  = 8,
    parameter int unsigned NUM_SRC        = 2
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [NUM_SRC*SET_ADDR_WIDTH-1:0]   i_src_set_addr,
    input  logic [NUM_SRC*SA_WORD_WIDTH-1:0]    i_src_data,
    input  logic [NUM_SRC*NUM_WAYS-1:0]         i_src_mask,
    input  logic [NUM_SRC-1:0]                  i_src_valid,
    output logic [NUM_SRC-1:0]                  o_src_ready,
    input  logic                                i_prio_mode,
    output logic [SET_ADDR_WIDTH-1:0]           o_w_set_addr,
    output logic [SA_WORD_WIDTH-1:0]            o_w_data,
    output logic [NUM_WAYS-1:0]                 o_w_mask,
    output logic                                o_w_valid,
    input  logic                                i_w_ready,
    output logic                                o_busy
);

    localparam int unsigned WAY_BITS = SA_WORD_WIDTH / NUM_WAYS;
    localparam int unsigned PTR_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]                slot_valid_q, slot_valid_d;
    logic [NUM_SRC*SET_ADDR_WIDTH-1:0] slot_addr_q, slot_addr_d;
    logic [NUM_SRC*SA_WORD_WIDTH-1:0]  slot_data_q, slot_data_d;
    logic [NUM_SRC*NUM_WAYS-1:0]       slot_mask_q, slot_mask_d;
    logic                              out_valid_q, out_valid_d;
    logic [SET_ADDR_WIDTH-1:0]         out_addr_q, out_addr_d;
    logic [SA_WORD_WIDTH-1:0]          out_data_q, out_data_d;
    logic [NUM_WAYS-1:0]               out_mask_q, out_mask_d;
    logic [PTR_W-1:0]                  rr_ptr_q, rr_ptr_d;

    // Grant selection, optional merge, output load and slot capture
    always_comb begin
        int                        idx;
        int                        win;
        int                        start;
        logic                      found;
        logic                      load;
        logic [NUM_SRC-1:0]        take;
        logic [SET_ADDR_WIDTH-1:0] m_addr;
        logic [SA_WORD_WIDTH-1:0]  m_data;
        logic [NUM_WAYS-1:0]       m_mask;
        logic [NUM_WAYS-1:0]       in_mask;

        slot_valid_d = slot_valid_q;
        slot_addr_d  = slot_addr_q;
        slot_data_d  = slot_data_q;
        slot_mask_d  = slot_mask_q;
        out_valid_d  = out_valid_q;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        out_mask_d   = out_mask_q;
        rr_ptr_d     = rr_ptr_q;
        idx          = 0;
        win          = 0;
        found        = 1'b0;
        take         = '0;
        m_addr       = '0;
        m_data       = '0;
        m_mask       = '0;
        in_mask      = '0;
        start        = i_prio_mode ? 0 : int'(rr_ptr_q);
        load         = ~out_valid_q | i_w_ready;

        // First valid slot in priority order wins
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            idx = start + i;
            if (idx >= int'(NUM_SRC)) idx = idx - int'(NUM_SRC);
            if (!found && slot_valid_q[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found) m_addr = slot_addr_q[win*SET_ADDR_WIDTH +: SET_ADDR_WIDTH];

        // Walk in priority order so each way keeps the highest-priority contributor
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            idx = start + i;
            if (idx >= int'(NUM_SRC)) idx = idx - int'(NUM_SRC);
`ifdef SA_W_ARB_MERGE_EN
            if (found && slot_valid_q[idx] &&
                slot_addr_q[idx*SET_ADDR_WIDTH +: SET_ADDR_WIDTH] == m_addr) begin
`else
            if (found && idx == win) begin
`endif
                take[idx] = 1'b1;
                for (int w = 0; w < int'(NUM_WAYS); w++) begin
                    if (slot_mask_q[idx*NUM_WAYS + w] && !m_mask[w]) begin
                        m_data[w*WAY_BITS +: WAY_BITS] =
                            slot_data_q[idx*SA_WORD_WIDTH + w*WAY_BITS +: WAY_BITS];
                    end
                end
                m_mask = m_mask | slot_mask_q[idx*NUM_WAYS +: NUM_WAYS];
            end
        end

        if (load) begin
            if (found) begin
                out_valid_d  = 1'b1;
                out_addr_d   = m_addr;
                out_data_d   = m_data;
                out_mask_d   = m_mask;
                slot_valid_d = slot_valid_q & ~take;
                if (!i_prio_mode) begin
                    rr_ptr_d = (win == int'(NUM_SRC) - 1) ? '0 : PTR_W'(win + 1);
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end

        // Capture only into empty slots; an all-zero mask is accepted and dropped
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            in_mask = i_src_mask[k*NUM_WAYS +: NUM_WAYS];
            if (i_src_valid[k] && !slot_valid_q[k] && (|in_mask)) begin
                slot_valid_d[k] = 1'b1;
                slot_addr_d[k*SET_ADDR_WIDTH +: SET_ADDR_WIDTH] =
                    i_src_set_addr[k*SET_ADDR_WIDTH +: SET_ADDR_WIDTH];
                slot_mask_d[k*NUM_WAYS +: NUM_WAYS] = in_mask;
                for (int w = 0; w < int'(NUM_WAYS); w++) begin
                    slot_data_d[k*SA_WORD_WIDTH + w*WAY_BITS +: WAY_BITS] = in_mask[w] ?
                        i_src_data[k*SA_WORD_WIDTH + w*WAY_BITS +: WAY_BITS] : '0;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            slot_valid_q <= '0;
            slot_addr_q  <= '0;
            slot_data_q  <= '0;
            slot_mask_q  <= '0;
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            out_mask_q   <= '0;
            rr_ptr_q     <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_addr_q  <= slot_addr_d;
            slot_data_q  <= slot_data_d;
            slot_mask_q  <= slot_mask_d;
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            out_mask_q   <= out_mask_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign o_src_ready  = ~slot_valid_q;
    assign o_w_valid    = out_valid_q;
    assign o_w_set_addr = out_addr_q;
    assign o_w_data     = out_data_q;
    assign o_w_mask     = out_mask_q;
    assign o_busy       = (|slot_valid_q) | out_valid_q;

endmodule

// File: tb/tb_sa_w_arb_q.sv
// tb_sa_w_arb_q: directed + randomized bench for sa_w_arb_q against a transaction-level
// reference model (slots as arrays, priority order computed with modulo arithmetic).
module tb_sa_w_arb_q;

    localparam int AW = 4;
    localparam int NW = 4;
    localparam int DW = 8;
    localparam int NS = 2;
    localparam int WB = DW / NW;

    logic              clk;
    logic              rst_n;
    logic [NS*AW-1:0]  src_addr;
    logic [NS*DW-1:0]  src_data;
    logic [NS*NW-1:0]  src_mask;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic              prio_mode;
    logic [AW-1:0]     w_addr;
    logic [DW-1:0]     w_data;
    logic [NW-1:0]     w_mask;
    logic              w_valid;
    logic              w_ready;
    logic              busy;

    sa_w_arb_q #(
        .SET_ADDR_WIDTH (AW),
        .NUM_WAYS       (NW),
        .SA_WORD_WIDTH  (DW),
        .NUM_SRC        (NS)
    ) u_dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_src_set_addr (src_addr),
        .i_src_data     (src_data),
        .i_src_mask     (src_mask),
        .i_src_valid    (src_valid),
        .o_src_ready    (src_ready),
        .i_prio_mode    (prio_mode),
        .o_w_set_addr   (w_addr),
        .o_w_data       (w_data),
        .o_w_mask       (w_mask),
        .o_w_valid      (w_valid),
        .i_w_ready      (w_ready),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: contents of each pending slot plus the output write
    logic          m_sv [NS];
    logic [AW-1:0] m_sa [NS];
    logic [DW-1:0] m_sd [NS];
    logic [NW-1:0] m_sm [NS];
    logic          m_ov;
    logic [AW-1:0] m_oa;
    logic [DW-1:0] m_od;
    logic [NW-1:0] m_om;
    int            m_rr;
    int            n_writes;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NS; k++) begin
            m_sv[k] = 1'b0; m_sa[k] = '0; m_sd[k] = '0; m_sm[k] = '0;
        end
        m_ov = 1'b0; m_oa = '0; m_od = '0; m_om = '0; m_rr = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        logic          old_v [NS];
        logic [NW-1:0] mk;
        int            win;
        int            s;
        logic          merge_ok;
        for (int k = 0; k < NS; k++) old_v[k] = m_sv[k];
        if (!m_ov || w_ready) begin
            win = -1;
            for (int i = 0; i < NS; i++) begin
                s = ((prio_mode ? 0 : m_rr) + i) % NS;
                if (win < 0 && old_v[s]) win = s;
            end
            if (win < 0) begin
                m_ov = 1'b0;
            end else begin
                m_ov = 1'b1; m_oa = m_sa[win]; m_od = '0; m_om = '0;
                for (int i = 0; i < NS; i++) begin
                    s = ((prio_mode ? 0 : m_rr) + i) % NS;
`ifdef SA_W_ARB_MERGE_EN
                    merge_ok = old_v[s] && (m_sa[s] == m_oa);
`else
                    merge_ok = (s == win);
`endif
                    if (merge_ok) begin
                        for (int w = 0; w < NW; w++)
                            if (m_sm[s][w] && !m_om[w]) m_od[w*WB +: WB] = m_sd[s][w*WB +: WB];
                        m_om = m_om | m_sm[s];
                        m_sv[s] = 1'b0;
                    end
                end
                if (!prio_mode) m_rr = (win + 1) % NS;
                n_writes++;
            end
        end
        for (int k = 0; k < NS; k++) begin
            mk = src_mask[k*NW +: NW];
            if (src_valid[k] && !old_v[k] && mk != 0) begin
                m_sv[k] = 1'b1;
                m_sa[k] = src_addr[k*AW +: AW];
                m_sm[k] = mk;
                for (int w = 0; w < NW; w++)
                    m_sd[k][w*WB +: WB] = mk[w] ? src_data[k*DW + w*WB +: WB] : '0;
            end
        end
    endtask

    task automatic check_outputs();
        logic any_v;
        logic [NS-1:0] rdy;
        any_v = m_ov;
        for (int k = 0; k < NS; k++) begin
            rdy[k] = ~m_sv[k];
            any_v  = any_v | m_sv[k];
        end
        check_eq("w_valid", 32'(w_valid), 32'(m_ov));
        check_eq("w_addr", 32'(w_addr), 32'(m_oa));
        check_eq("w_data", 32'(w_data), 32'(m_od));
        check_eq("w_mask", 32'(w_mask), 32'(m_om));
        check_eq("src_ready", 32'(src_ready), 32'(rdy));
        check_eq("busy", 32'(busy), 32'(any_v));
    endtask

    // Called at a negedge with inputs set: step model over the next posedge, check after it
    task automatic tick();
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_src(input int k, input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [NW-1:0] m);
        src_valid[k]          = v;
        src_addr[k*AW +: AW]  = a;
        src_data[k*DW +: DW]  = d;
        src_mask[k*NW +: NW]  = m;
    endtask

    task automatic drain();
        src_valid = '0;
        w_ready   = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic rand_inputs(input int addr_range);
        for (int k = 0; k < NS; k++)
            set_src(k, 1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, addr_range)),
                    DW'($urandom), NW'($urandom));
    endtask

    initial begin
        rst_n     = 1'b0;
        src_valid = '0;
        src_addr  = '0;
        src_data  = '0;
        src_mask  = '0;
        prio_mode = 1'b1;
        w_ready   = 1'b1;
        n_writes  = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Single write with mask sanitising
        drain();
        set_src(1, 1'b1, 4'h3, 8'hFF, 4'b0101);
        tick();
        src_valid = '0;
        tick();
        check_eq("single_valid", 32'(w_valid), 32'h1);
        check_eq("single_data", 32'(w_data), 32'h33);
        tick();
        check_eq("single_once", 32'(w_valid), 32'h0);

        // Zero mask accepted but never issued
        set_src(0, 1'b1, 4'h1, 8'hAA, 4'b0000);
        tick();
        src_valid = '0;
        tick();
        check_eq("zmask_nowrite", 32'(w_valid), 32'h0);

        // Two same-set requests pending together in strict mode
        prio_mode = 1'b1;
        set_src(0, 1'b1, 4'h2, 8'h05, 4'b0011);
        set_src(1, 1'b1, 4'h2, 8'h28, 4'b0110);
        tick();
        src_valid = '0;
        tick();
`ifdef SA_W_ARB_MERGE_EN
        check_eq("merge_mask", 32'(w_mask), 32'h7);
        check_eq("merge_data", 32'(w_data), 32'h25);
`else
        check_eq("nomerge_mask0", 32'(w_mask), 32'h3);
`endif
        drain();

        // Strict priority, then round-robin with a mode swap, continuous requests
        for (int mode = 1; mode >= 0; mode--) begin
            prio_mode = 1'(mode);
            for (int i = 0; i < 20; i++) begin
                for (int k = 0; k < NS; k++)
                    set_src(k, 1'b1, AW'(k * 4 + i % 4), DW'($urandom), 4'b1111);
                if (mode == 0 && i == 15) prio_mode = 1'b1;
                tick();
            end
        end
        drain();

        // Backpressure: fill everything, hold 5 cycles, release
        prio_mode = 1'b0;
        for (int k = 0; k < NS; k++) set_src(k, 1'b1, AW'(k + 8), DW'($urandom), 4'b1111);
        w_ready = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check_eq("bp_ready", 32'(src_ready), 32'h0);
        check_eq("bp_valid", 32'(w_valid), 32'h1);
        src_valid = '0;
        w_ready   = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // Randomized traffic with a mid-stream asynchronous reset
        for (int i = 0; i < 600; i++) begin
            rand_inputs(3);
            prio_mode = (i % 100 < 50) ? 1'($urandom_range(0, 1)) : 1'b0;
            w_ready   = 1'($urandom_range(0, 3) != 0);
            if (i == 300) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                check_eq("rst_valid", 32'(w_valid), 32'h0);
                check_eq("rst_fields", 32'({w_addr, w_data, w_mask}), 32'h0);
                check_eq("rst_ready", 32'(src_ready), 32'h3);
                @(negedge clk);
                check_outputs();
                @(negedge clk);
                rst_n = 1'b1;
                check_outputs();
            end
            tick();
        end
        drain();
        check_eq("end_idle", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
